// File: rtl/alu_reservation_station_if.sv
// -----------------------------------------------------------------------------
// alu_reservation_station_if
// Bundles the dispatch, broadcast and ALU-request buses of the ALU reservation
// station.
//   master : drives dispatch and broadcast buses, observes full_out and the
//            ALU request (dispatcher / ALU / LSB side, or a testbench)
//   slave  : the reservation station itself
// Signals:
//   dsp_*        dispatch request, operands, producer tags, destination tag
//   full_out     no free entry
//   alu_bc_*     ALU result broadcast
//   lsb_bc_*     load/store buffer result broadcast
//   alu_*_out    issued micro-op towards the combinational ALU
// -----------------------------------------------------------------------------
interface alu_reservation_station_if #(
    parameter int OP_W      = 6,
    parameter int ROB_TAG_W = 4
);
    logic                 dsp_valid_in;
    logic [OP_W-1:0]      dsp_op_in;
    logic [31:0]          dsp_imm_in;
    logic [31:0]          dsp_pc_in;
    logic [31:0]          dsp_rs1val_in;
    logic [ROB_TAG_W-1:0] dsp_rs1tag_in;
    logic [31:0]          dsp_rs2val_in;
    logic [ROB_TAG_W-1:0] dsp_rs2tag_in;
    logic [ROB_TAG_W-1:0] dsp_dest_in;
    logic                 full_out;

    logic                 alu_bc_signal_in;
    logic [31:0]          alu_bc_result_in;
    logic [ROB_TAG_W-1:0] alu_bc_tag_in;
    logic                 lsb_bc_signal_in;
    logic [31:0]          lsb_bc_result_in;
    logic [ROB_TAG_W-1:0] lsb_bc_tag_in;

    logic                 alu_calculate_signal_out;
    logic [OP_W-1:0]      alu_op_out;
    logic [31:0]          alu_imm_out;
    logic [31:0]          alu_pc_out;
    logic [31:0]          alu_rs1val_out;
    logic [31:0]          alu_rs2val_out;
    logic [ROB_TAG_W-1:0] alu_dest_out;

    modport master (
        output dsp_valid_in, dsp_op_in, dsp_imm_in, dsp_pc_in,
               dsp_rs1val_in, dsp_rs1tag_in, dsp_rs2val_in, dsp_rs2tag_in,
               dsp_dest_in,
               alu_bc_signal_in, alu_bc_result_in, alu_bc_tag_in,
               lsb_bc_signal_in, lsb_bc_result_in, lsb_bc_tag_in,
        input  full_out,
               alu_calculate_signal_out, alu_op_out, alu_imm_out, alu_pc_out,
               alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );

    modport slave (
        input  dsp_valid_in, dsp_op_in, dsp_imm_in, dsp_pc_in,
               dsp_rs1val_in, dsp_rs1tag_in, dsp_rs2val_in, dsp_rs2tag_in,
               dsp_dest_in,
               alu_bc_signal_in, alu_bc_result_in, alu_bc_tag_in,
               lsb_bc_signal_in, lsb_bc_result_in, lsb_bc_tag_in,
        output full_out,
               alu_calculate_signal_out, alu_op_out, alu_imm_out, alu_pc_out,
               alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );
endinterface

// File: rtl/alu_reservation_station.sv
// -----------------------------------------------------------------------------
// alu_reservation_station
// Holds dispatched ALU-class micro-ops until both source operands are known,
// then issues the lowest-index ready entry (one per cycle) to the ALU.
// Ports:
//   clk_in           clock
//   rst_in           synchronous active-high reset
//   rdy_in           global ready, low freezes the block
//   rob_rollback_in  misprediction flush, empties the station
//   bus              alu_reservation_station_if.slave (dispatch, broadcasts,
//                    full_out, ALU request)
// Build option:
//   RS_WAKEUP_BYPASS_EN  entries whose outstanding tags are all satisfied by the
//                        current broadcasts may issue at that same edge, with
//                        the broadcast values substituted.
// -----------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      rob_rollback_in,
    alu_reservation_station_if.slave  bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic                 r_busy [RS_SIZE];
    logic [OP_W-1:0]      r_op   [RS_SIZE];
    logic [31:0]          r_imm  [RS_SIZE];
    logic [31:0]          r_pc   [RS_SIZE];
    logic [31:0]          r_vj   [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_qj   [RS_SIZE];
    logic [31:0]          r_vk   [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_qk   [RS_SIZE];
    logic [ROB_TAG_W-1:0] r_dest [RS_SIZE];
    logic [CNT_W-1:0]     r_count;

    logic                 r_calc;
    logic [OP_W-1:0]      r_op_o;
    logic [31:0]          r_imm_o;
    logic [31:0]          r_pc_o;
    logic [31:0]          r_rs1_o;
    logic [31:0]          r_rs2_o;
    logic [ROB_TAG_W-1:0] r_dest_o;

    logic                 w_j_hit [RS_SIZE];
    logic                 w_k_hit [RS_SIZE];
    logic [31:0]          w_vj_bc [RS_SIZE];
    logic [31:0]          w_vk_bc [RS_SIZE];
    logic                 w_ready [RS_SIZE];
    logic                 w_free_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_sel_found;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_full;
    logic                 w_accept;
    logic [31:0]          w_iss_vj;
    logic [31:0]          w_iss_vk;
    logic [31:0]          w_dsp_vj;
    logic [ROB_TAG_W-1:0] w_dsp_qj;
    logic [31:0]          w_dsp_vk;
    logic [ROB_TAG_W-1:0] w_dsp_qk;

    assign w_full   = (r_count == CNT_W'(RS_SIZE));
    assign w_accept = bus.dsp_valid_in && !w_full && w_free_found;

    // Per-entry broadcast match; tag 0 never matches since it means "no wait".
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_j_hit[i] = (r_qj[i] != '0) &&
                         ((bus.alu_bc_signal_in && r_qj[i] == bus.alu_bc_tag_in) ||
                          (bus.lsb_bc_signal_in && r_qj[i] == bus.lsb_bc_tag_in));
            w_k_hit[i] = (r_qk[i] != '0) &&
                         ((bus.alu_bc_signal_in && r_qk[i] == bus.alu_bc_tag_in) ||
                          (bus.lsb_bc_signal_in && r_qk[i] == bus.lsb_bc_tag_in));
            w_vj_bc[i] = (bus.alu_bc_signal_in && r_qj[i] == bus.alu_bc_tag_in) ?
                         bus.alu_bc_result_in : bus.lsb_bc_result_in;
            w_vk_bc[i] = (bus.alu_bc_signal_in && r_qk[i] == bus.alu_bc_tag_in) ?
                         bus.alu_bc_result_in : bus.lsb_bc_result_in;
`ifdef RS_WAKEUP_BYPASS_EN
            w_ready[i] = r_busy[i] && (r_qj[i] == '0 || w_j_hit[i]) &&
                                      (r_qk[i] == '0 || w_k_hit[i]);
`else
            w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
`endif
        end
    end

    // Lowest-index search: scanning downwards leaves the smallest match last.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
`ifdef RS_WAKEUP_BYPASS_EN
        w_iss_vj = (r_qj[w_sel_idx] == '0) ? r_vj[w_sel_idx] : w_vj_bc[w_sel_idx];
        w_iss_vk = (r_qk[w_sel_idx] == '0) ? r_vk[w_sel_idx] : w_vk_bc[w_sel_idx];
`else
        w_iss_vj = r_vj[w_sel_idx];
        w_iss_vk = r_vk[w_sel_idx];
`endif
    end

    // Dispatch-time forwarding from either broadcast bus.
    always_comb begin
        w_dsp_vj = bus.dsp_rs1val_in;
        w_dsp_qj = bus.dsp_rs1tag_in;
        w_dsp_vk = bus.dsp_rs2val_in;
        w_dsp_qk = bus.dsp_rs2tag_in;
        if (bus.dsp_rs1tag_in != '0) begin
            if (bus.alu_bc_signal_in && bus.alu_bc_tag_in == bus.dsp_rs1tag_in) begin
                w_dsp_vj = bus.alu_bc_result_in;
                w_dsp_qj = '0;
            end else if (bus.lsb_bc_signal_in && bus.lsb_bc_tag_in == bus.dsp_rs1tag_in) begin
                w_dsp_vj = bus.lsb_bc_result_in;
                w_dsp_qj = '0;
            end
        end
        if (bus.dsp_rs2tag_in != '0) begin
            if (bus.alu_bc_signal_in && bus.alu_bc_tag_in == bus.dsp_rs2tag_in) begin
                w_dsp_vk = bus.alu_bc_result_in;
                w_dsp_qk = '0;
            end else if (bus.lsb_bc_signal_in && bus.lsb_bc_tag_in == bus.dsp_rs2tag_in) begin
                w_dsp_vk = bus.lsb_bc_result_in;
                w_dsp_qk = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
            r_count  <= '0;
            r_calc   <= 1'b0;
            r_op_o   <= '0;
            r_imm_o  <= '0;
            r_pc_o   <= '0;
            r_rs1_o  <= '0;
            r_rs2_o  <= '0;
            r_dest_o <= '0;
        end else if (rob_rollback_in) begin
            for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
            r_count <= '0;
            r_calc  <= 1'b0;
        end else if (!rdy_in) begin
            r_calc <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && w_j_hit[i]) begin
                    r_vj[i] <= w_vj_bc[i];
                    r_qj[i] <= '0;
                end
                if (r_busy[i] && w_k_hit[i]) begin
                    r_vk[i] <= w_vk_bc[i];
                    r_qk[i] <= '0;
                end
            end

            r_calc <= w_sel_found;
            if (w_sel_found) begin
                r_op_o            <= r_op[w_sel_idx];
                r_imm_o           <= r_imm[w_sel_idx];
                r_pc_o            <= r_pc[w_sel_idx];
                r_rs1_o           <= w_iss_vj;
                r_rs2_o           <= w_iss_vk;
                r_dest_o          <= r_dest[w_sel_idx];
                r_busy[w_sel_idx] <= 1'b0;
            end

            // The free slot comes from pre-edge busy bits, so it can never be
            // the entry being issued at this edge.
            if (w_accept) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= bus.dsp_op_in;
                r_imm[w_free_idx]  <= bus.dsp_imm_in;
                r_pc[w_free_idx]   <= bus.dsp_pc_in;
                r_vj[w_free_idx]   <= w_dsp_vj;
                r_qj[w_free_idx]   <= w_dsp_qj;
                r_vk[w_free_idx]   <= w_dsp_vk;
                r_qk[w_free_idx]   <= w_dsp_qk;
                r_dest[w_free_idx] <= bus.dsp_dest_in;
            end

            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_sel_found);
        end
    end

    assign bus.full_out                 = w_full;
    assign bus.alu_calculate_signal_out = r_calc;
    assign bus.alu_op_out               = r_op_o;
    assign bus.alu_imm_out              = r_imm_o;
    assign bus.alu_pc_out               = r_pc_o;
    assign bus.alu_rs1val_out           = r_rs1_o;
    assign bus.alu_rs2val_out           = r_rs2_o;
    assign bus.alu_dest_out             = r_dest_o;

endmodule
